// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the sync_fifo block.
package sync_fifo_pkg;

  localparam int unsigned DefaultDataWidth = 8;
  localparam int unsigned DefaultDepth     = 16;

  typedef logic [DefaultDataWidth-1:0] fifo_word_t;

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bus for sync_fifo; SYNC_FIFO_LEVEL_EN adds the fifo_level signal.
interface sync_fifo_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
);

  logic [DATA_WIDTH-1:0] data_in;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  en;
  logic                  fifo_full;
  logic                  fifo_empty;
`ifdef SYNC_FIFO_LEVEL_EN
  logic [ADDR_WIDTH:0]   fifo_level;

  modport master (
    output data_in, push, pop,
    input  data_out, en, fifo_full, fifo_empty, fifo_level
  );
  modport slave (
    input  data_in, push, pop,
    output data_out, en, fifo_full, fifo_empty, fifo_level
  );
`else
  modport master (
    output data_in, push, pop,
    input  data_out, en, fifo_full, fifo_empty
  );
  modport slave (
    input  data_in, push, pop,
    output data_out, en, fifo_full, fifo_empty
  );
`endif

endinterface

// File: rtl/sync_fifo_ram.sv
// Register array with one write port and a registered read port; read data resets to 0.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned DEPTH      = DefaultDepth,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Same-address read and write returns the old word (full + push + pop case).
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO: pointers, count and flags; storage in sync_fifo_ram.
// Define SYNC_FIFO_LEVEL_EN to expose the occupancy count as fifo_level.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned DEPTH      = DefaultDepth,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  sync_fifo_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0] FullCount = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  en_q, en_d;
  logic                  full, empty;
  logic                  wr_ok, rd_ok;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);

  // A pop frees a slot in the same cycle, so push is accepted when full if popping.
  assign wr_ok = bus.push & (~full | bus.pop);
  assign rd_ok = bus.pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    en_d     = rd_ok;
    if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      en_q     <= en_d;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.data_in),
    .re_i    (rd_ok),
    .raddr_i (rd_ptr_q),
    .rdata_o (bus.data_out)
  );

  assign bus.en         = en_q;
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
`ifdef SYNC_FIFO_LEVEL_EN
  assign bus.fifo_level = count_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a vector table plus hand-written fill/wrap/full sequences.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int unsigned Depth = 16;

  typedef struct {
    logic       rst_n;
    logic       push;
    logic       pop;
    fifo_word_t din;
    fifo_word_t exp_do;
    logic       exp_en;
    logic       exp_full;
    logic       exp_empty;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_mis = 0;
  vec_t vecs[18];

  sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(Depth)) bus ();

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(Depth)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic p, input logic q, input fifo_word_t d);
    reset        = r;
    bus.push     = p;
    bus.pop      = q;
    bus.data_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input fifo_word_t e_do, input logic e_en,
                            input logic e_full, input logic e_empty);
    n_vec++;
    if ({bus.data_out, bus.en, bus.fifo_full, bus.fifo_empty} !== {e_do, e_en, e_full, e_empty})
    begin
      n_mis++;
      $display("FAIL %s: got do=%02h en=%b full=%b empty=%b, want do=%02h en=%b full=%b empty=%b",
               name, bus.data_out, bus.en, bus.fifo_full, bus.fifo_empty,
               e_do, e_en, e_full, e_empty);
    end
  endtask

  initial begin
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;

    //            rst  push pop  din     do     en    full  empty
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h09, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h05, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h09, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h09, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 8'h07, 8'h09, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h07, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h03, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h04, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 8'h06, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};

    for (int v = 0; v < 18; v++) begin
      step(vecs[v].rst_n, vecs[v].push, vecs[v].pop, vecs[v].din);
      expect_out($sformatf("vec%0d", v), vecs[v].exp_do, vecs[v].exp_en,
                 vecs[v].exp_full, vecs[v].exp_empty);
    end

    // Offset the pointers by one so each fill round straddles the wrap point.
    step(1'b1, 1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    expect_out("offset_pop", 8'h11, 1'b1, 1'b0, 1'b1);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < int'(Depth); i++) begin
        step(1'b1, 1'b1, 1'b0, fifo_word_t'(i));
        expect_out($sformatf("fill_r%0d_%0d", r, i), 8'h11 * fifo_word_t'(r == 0 ? 1 : 0)
                   + (r == 0 ? 8'h00 : fifo_word_t'(Depth - 1)), 1'b0,
                   (i == int'(Depth) - 1), 1'b0);
      end
      step(1'b1, 1'b1, 1'b0, 8'hAA);
      expect_out($sformatf("overflow_r%0d", r), (r == 0) ? 8'h11 : fifo_word_t'(Depth - 1),
                 1'b0, 1'b1, 1'b0);
`ifdef SYNC_FIFO_LEVEL_EN
      n_vec++;
      if (bus.fifo_level !== 5'(Depth)) begin
        n_mis++;
        $display("FAIL level_full_r%0d: got %0d, want %0d", r, bus.fifo_level, Depth);
      end
`endif
      for (int i = 0; i < int'(Depth); i++) begin
        step(1'b1, 1'b0, 1'b1, 8'h00);
        expect_out($sformatf("drain_r%0d_%0d", r, i), fifo_word_t'(i), 1'b1, 1'b0,
                   (i == int'(Depth) - 1));
      end
      step(1'b1, 1'b0, 1'b1, 8'h00);
      expect_out($sformatf("drained_r%0d", r), fifo_word_t'(Depth - 1), 1'b0, 1'b0, 1'b1);
    end

    // Full with simultaneous push and pop: oldest out, new word goes last.
    for (int i = 0; i < int'(Depth); i++) begin
      step(1'b1, 1'b1, 1'b0, 8'h20 + fifo_word_t'(i));
    end
    expect_out("full_again", fifo_word_t'(Depth - 1), 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'h77);
    expect_out("full_pushpop", 8'h20, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < int'(Depth); i++) begin
      step(1'b1, 1'b0, 1'b1, 8'h00);
      expect_out($sformatf("full_drain_%0d", i), 8'h20 + fifo_word_t'(i), 1'b1, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 1'b1, 8'h00);
    expect_out("full_last", 8'h77, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    expect_out("idle_after", 8'h77, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock synchronous FIFO that buffers bytes between a producer and a consumer that share one clock domain. Writes are requested with `push` and reads with `pop`. Read data is returned from a register one cycle after the pop, together with a one-cycle valid strobe `en`. `fifo_full` and `fifo_empty` let both sides throttle their requests.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 16, number of entries. Must be a power of two and at least 2.
- ADDR_WIDTH, $clog2(DEPTH), derived pointer width. Not intended to be overridden.

Ports:
- clk  input  1  sole clock; all logic is sampled on its rising edge.
- reset  input  1  synchronous, active-low reset (reset asserted when 0).
- data_in  input  DATA_WIDTH  write data, sampled when a push is accepted.
- push  input  1  write request; level-sensitive, one write per cycle while high.
- pop  input  1  read request; level-sensitive, one read per cycle while high.
- data_out  output  DATA_WIDTH  registered read data; holds its value until the next accepted pop.
- en  output  1  read-valid strobe; high for exactly the one cycle in which data_out presents newly popped data.
- fifo_full  output  1  high when the FIFO holds DEPTH entries.
- fifo_empty  output  1  high when the FIFO holds 0 entries.

## Operation
- Storage is a DEPTH x DATA_WIDTH register array with a write pointer, a read pointer and a count. The count is ADDR_WIDTH+1 bits wide.
- Pointers are ADDR_WIDTH bits wide and wrap naturally from DEPTH-1 to 0.
- Accepted write: `wr_ok = push & (!fifo_full | pop)`. It stores data_in at the write pointer and increments the write pointer.
- Accepted read: `rd_ok = pop & !fifo_empty`. It loads mem[read pointer] into data_out, increments the read pointer, and sets en=1 for the next cycle.
- Count update: count +1 on write only, -1 on read only, unchanged when both or neither occur.
- Push while full with no pop: the write is dropped. Data, pointers and count are unchanged, with no error indication.
- Pop while empty: ignored. data_out holds its value and en stays 0.
- Push and pop both asserted while empty: only the write occurs; the read is not accepted. The write data is poppable from the next cycle.
- Push and pop both asserted while full: both are accepted. The oldest word is read, the new word is written, and the FIFO stays full.
- Flags are decoded combinationally from the registered count: fifo_empty = (count==0), fifo_full = (count==DEPTH).

## Timing
- Reset (reset==0 at a clk edge): pointers=0, count=0, data_out=0, en=0, so fifo_empty=1 and fifo_full=0. Memory contents are not reset.
- Reset mid-operation discards all stored data at that edge.
- Write latency: a word pushed at edge N can be popped from edge N+1 onward.
- Read latency: a pop accepted at edge N gives data_out and en=1 valid after edge N, for the cycle N..N+1.
- Flags update at the same edge that changes the count.
- Throughput: one push and one pop per cycle.

## Configuration
- `SYNC_FIFO_LEVEL_EN` defined: adds output port `fifo_level` [ADDR_WIDTH:0]. It equals the internal count and resets to 0.
- `SYNC_FIFO_LEVEL_EN` undefined: the port is absent and all other behaviour is identical.

## Structure
- Shared package `sync_fifo_pkg`: default DATA_WIDTH and DEPTH constants, plus a `fifo_word_t` typedef of logic [DATA_WIDTH-1:0].
- Natural sub-module: `sync_fifo_ram`, a simple dual-port register array with a write port and a synchronous read port. Pointer, count and flag logic stay in the top module.

## Test plan
- Reset and empty pop: hold reset=0 for 2 cycles, release, then pop=1 for 2 cycles. Required: fifo_empty=1, fifo_full=0, data_out=0, en=0 throughout.
- Basic FIFO order: push 5 then 9 on consecutive cycles, idle, then pop for 3 cycles. Required: data_out=5 with en=1, then 9 with en=1, then en=0 with data_out still 9 and fifo_empty=1.
- Fill, overflow and wrap: push 0..DEPTH-1, which sets fifo_full=1, then push 0xAA once. Required: 0xAA is dropped, and popping all entries returns 0..DEPTH-1 in order. Repeat twice to exercise pointer wrap-around.
- Simultaneous push and pop while full: with the FIFO full, push 0x77 with pop=1 for one cycle. Required: oldest word is output, fifo_full stays 1, and 0x77 is popped last.
- Simultaneous push and pop while empty: push 7 with pop=1 for one cycle. Required: en=0 that cycle, fifo_empty=0 afterward, and the next pop returns 7.
- Reset mid-operation: push 3 words, assert reset for one edge. Required: fifo_empty=1, en=0, data_out=0, and a subsequent pop returns nothing (en stays 0).
